// File: rtl/port_bus_arbiter.sv
// Two-master round-robin arbiter for the 8-bit housekeeping port bus, with bounded burst locking.
// The port side keeps the existing port_id/out_port plus one-cycle strobe protocol.
module port_bus_arbiter #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned MAX_BURST    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    input  logic       m0_lock,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    input  logic       m1_lock,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    output logic [1:0] grant
);
    localparam logic [3:0] SetupLast = 4'(SETUP_CYCLES - 1);
    localparam logic [7:0] MaxBurst  = 8'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StAck} state_e;

    state_e     state_q, state_d;
    logic [3:0] setup_cnt_q, setup_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       rr_last_q, rr_last_d;  // 0 = m0, 1 = m1
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic [7:0] port_id_q, port_id_d;
    logic [7:0] out_port_q, out_port_d;
    logic [7:0] m0_rdata_q, m0_rdata_d;
    logic [7:0] m1_rdata_q, m1_rdata_d;
    logic [1:0] grant_q, grant_d;

    logic last_req, last_lock, owner_lock, lock_win, winner;

    always_comb begin
        last_req   = rr_last_q ? m1_req : m0_req;
        last_lock  = rr_last_q ? m1_lock : m0_lock;
        owner_lock = owner_q ? m1_lock : m0_lock;
        // A nonzero burst count means the last owner finished with lock held.
        lock_win   = last_req && last_lock && (burst_cnt_q != 8'd0) && (burst_cnt_q < MaxBurst);
        if (lock_win) begin
            winner = rr_last_q;
        end else if (m0_req && m1_req) begin
            winner = ~rr_last_q;
        end else begin
            winner = m1_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        burst_cnt_d = burst_cnt_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        port_id_d   = port_id_q;
        out_port_d  = out_port_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        grant_d     = grant_q;
        unique case (state_q)
            StIdle: begin
                grant_d = 2'b00;
                if (m0_req || m1_req) begin
                    owner_d     = winner;
                    grant_d     = winner ? 2'b10 : 2'b01;
                    we_d        = winner ? m1_we : m0_we;
                    port_id_d   = winner ? m1_addr : m0_addr;
                    out_port_d  = winner ? m1_wdata : m0_wdata;
                    setup_cnt_d = 4'd0;
                    state_d     = (SETUP_CYCLES == 0) ? StStrobe : StSetup;
                end
            end
            StSetup: begin
                if (setup_cnt_q == SetupLast) begin
                    state_d = StStrobe;
                end else begin
                    setup_cnt_d = setup_cnt_q + 4'd1;
                end
            end
            StStrobe: begin
                if (!we_q) begin
                    if (owner_q) begin
                        m1_rdata_d = in_port;
                    end else begin
                        m0_rdata_d = in_port;
                    end
                end
                state_d = StAck;
            end
            StAck: begin
                rr_last_d = owner_q;
                // A new owner, or one that already used its full burst, starts counting afresh.
                if (!owner_lock) begin
                    burst_cnt_d = 8'd0;
                end else if ((owner_q != rr_last_q) || (burst_cnt_q >= MaxBurst)) begin
                    burst_cnt_d = 8'd1;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            setup_cnt_q <= 4'd0;
            burst_cnt_q <= 8'd0;
            rr_last_q   <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            port_id_q   <= 8'd0;
            out_port_q  <= 8'd0;
            m0_rdata_q  <= 8'd0;
            m1_rdata_q  <= 8'd0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            port_id_q   <= port_id_d;
            out_port_q  <= out_port_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            grant_q     <= grant_d;
        end
    end

    assign write_strobe = (state_q == StStrobe) && we_q;
    assign read_strobe  = (state_q == StStrobe) && !we_q;
    assign m0_ack       = (state_q == StAck) && !owner_q;
    assign m1_ack       = (state_q == StAck) && owner_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign port_id      = port_id_q;
    assign out_port     = out_port_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_port_bus_arbiter.sv
// Bench for port_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model; a second instance covers SETUP_CYCLES = 0.
module tb_port_bus_arbiter;
    localparam int unsigned S    = 1;
    localparam int unsigned MaxB = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req, we, lock;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic [7:0] in_port;
    logic       m0_ack, m1_ack, write_strobe, read_strobe;
    logic [7:0] m0_rdata, m1_rdata, port_id, out_port;
    logic [1:0] grant;

    logic       z_req, z_we;
    logic [7:0] z_addr, z_wdata;
    logic       z_m0_ack, z_m1_ack, z_write_strobe, z_read_strobe;
    logic [7:0] z_m0_rdata, z_m1_rdata, z_port_id, z_out_port;
    logic [1:0] z_grant;

    port_bus_arbiter #(.SETUP_CYCLES(S), .MAX_BURST(MaxB)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_lock(lock[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_lock(lock[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .in_port(in_port), .grant(grant)
    );

    port_bus_arbiter #(.SETUP_CYCLES(0), .MAX_BURST(MaxB)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .m0_req(z_req), .m0_we(z_we), .m0_addr(z_addr), .m0_wdata(z_wdata),
        .m0_lock(1'b0), .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(8'h00), .m1_wdata(8'h00),
        .m1_lock(1'b0), .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
        .port_id(z_port_id), .out_port(z_out_port), .write_strobe(z_write_strobe),
        .read_strobe(z_read_strobe), .in_port(8'h00), .grant(z_grant)
    );

    always #5 clk = ~clk;

    // Reference model: m_k counts cycles since grant (strobe at S+1, ack at S+2).
    bit          m_busy, m_own, m_we, m_rr;
    int unsigned m_k, m_run;
    logic [7:0]  m_id, m_out;
    logic [7:0]  m_rd [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] s_ack, s_grant, e_ack, zs_grant;
    logic       s_ws, s_rs, zs_ws, zs_ack;
    logic [7:0] s_id, s_od, s_rd0, s_rd1, zs_id;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_own = 1'b0; m_we = 1'b0; m_rr = 1'b1;
        m_k = 0; m_run = 0; m_id = 8'h00; m_out = 8'h00;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    endtask

    task automatic model_step();
        bit w, keep;
        if (!m_busy) begin
            if (req != 2'b00) begin
                keep = (m_run > 0) && (m_run < MaxB) && req[m_rr] && lock[m_rr];
                if (keep) w = m_rr;
                else if (req == 2'b11) w = !m_rr;
                else w = req[1];
                m_busy = 1'b1; m_k = 1; m_own = w;
                m_we = we[w]; m_id = addr[w]; m_out = wdata[w];
            end
        end else if (m_k == S + 2) begin
            if (!lock[m_own]) m_run = 0;
            else if ((m_own != m_rr) || (m_run >= MaxB)) m_run = 1;
            else m_run++;
            m_rr = m_own; m_busy = 1'b0; m_k = 0;
        end else begin
            if ((m_k == S + 1) && !m_we) m_rd[m_own] = in_port;
            m_k++;
        end
    endtask

    // Compare at the falling edge, advance the model, return just after the next rising edge.
    task automatic cycle();
        logic [1:0] eg, ea;
        logic       ews, ers;
        @(negedge clk);
        eg  = m_busy ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        ews = m_busy && (m_k == S + 1) && m_we;
        ers = m_busy && (m_k == S + 1) && !m_we;
        ea  = (m_busy && (m_k == S + 2)) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        check("grant", 8'(grant), 8'(eg));
        check("strobes", 8'({write_strobe, read_strobe}), 8'({ews, ers}));
        check("acks", 8'({m1_ack, m0_ack}), 8'(ea));
        check("port_id", port_id, m_id);
        check("out_port", out_port, m_out);
        check("m0_rdata", m0_rdata, m_rd[0]);
        check("m1_rdata", m1_rdata, m_rd[1]);
        s_ack = {m1_ack, m0_ack}; s_grant = grant; s_ws = write_strobe; s_rs = read_strobe;
        s_id = port_id; s_od = out_port; s_rd0 = m0_rdata; s_rd1 = m1_rdata; e_ack = ea;
        zs_ws = z_write_strobe; zs_ack = z_m0_ack; zs_id = z_port_id; zs_grant = z_grant;
        if (!reset_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int q_own[$];
        int q_cyc[$];
        int both, rs_cnt, ack_c, lead, acks_in_rst, first_own, first_s;
        logic [7:0] rd1_at_ack;

        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
        in_port = 8'h00; z_req = 1'b0; z_we = 1'b0; z_addr = 8'h00; z_wdata = 8'h00;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        model_reset();
        repeat (3) cycle();
        check("rst_grant", 8'(s_grant), 8'h00);
        check("rst_strobes", 8'({s_ws, s_rs}), 8'h00);
        check("rst_acks", 8'(s_ack), 8'h00);
        check("rst_port_id", s_id, 8'h00);
        reset_n = 1'b1;
        cycle();

        // Lone write from m0
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h1F; wdata[0] = 8'h31;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (c == 3) req[0] = 1'b0;
            if (c >= 1) begin
                check("lw_port_id", s_id, 8'h1F);
                check("lw_out_port", s_od, 8'h31);
            end
            check("lw_grant", 8'(s_grant), (c >= 1 && c <= 3) ? 8'h01 : 8'h00);
            check("lw_wstrobe", 8'(s_ws), 8'(c == 2));
            check("lw_m0_ack", 8'(s_ack[0]), 8'(c == 3));
        end

        // Lone read from m1
        in_port = 8'hA5; req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h21;
        rs_cnt = 0; ack_c = -1; rd1_at_ack = 8'h00;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (c == 3) req[1] = 1'b0;
            rs_cnt += int'(s_rs);
            if (s_ack[1]) begin
                ack_c = c;
                rd1_at_ack = s_rd1;
            end
        end
        check("lr_rstrobe_count", 8'(rs_cnt), 8'd1);
        check("lr_ack_cycle", 8'(ack_c), 8'd3);
        check("lr_m1_rdata", rd1_at_ack, 8'hA5);
        check("lr_m0_rdata", s_rd0, 8'h00);

        // Contention, no lock: strict alternation starting with m0
        do_reset();
        req = 2'b11; we = 2'b11; lock = 2'b00; addr[0] = 8'h10; addr[1] = 8'h20;
        both = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_ack == 2'b11) both++;
            if (s_ack[0]) begin q_own.push_back(0); q_cyc.push_back(c); end
            if (s_ack[1]) begin q_own.push_back(1); q_cyc.push_back(c); end
        end
        check("ct_ack_count", 8'(q_own.size()), 8'd5);
        check("ct_both_acks", 8'(both), 8'd0);
        if (q_cyc.size() > 0) check("ct_first_ack", 8'(q_cyc[0]), 8'd3);
        for (int i = 0; i < 4 && i + 1 < q_own.size(); i++) begin
            check("ct_order", 8'(q_own[i]), 8'(i % 2));
            check("ct_spacing", 8'(q_cyc[i + 1] - q_cyc[i]), 8'd4);
        end

        // Burst lock: m0 locked keeps the bus for MAX_BURST transactions
        q_own.delete(); q_cyc.delete();
        do_reset();
        req = 2'b11; lock = 2'b01;
        for (int c = 0; c < 90; c++) begin
            cycle();
            if (s_ack[0]) q_own.push_back(0);
            if (s_ack[1]) q_own.push_back(1);
        end
        lead = 0;
        while (lead < q_own.size() && q_own[lead] == 0) lead++;
        check("bl_m0_run", 8'(lead), 8'd16);
        check("bl_ack_count", 8'(q_own.size()), 8'd22);
        if (q_own.size() >= 22) begin
            check("bl_m1_turn", 8'(q_own[16]), 8'd1);
            for (int i = 17; i < 22; i++) check("bl_m0_resume", 8'(q_own[i]), 8'd0);
        end

        // Reset during the strobe cycle
        do_reset();
        req = 2'b01; lock = 2'b00; we[0] = 1'b1; addr[0] = 8'h5A; wdata[0] = 8'h66;
        repeat (2) cycle();
        #1;
        check("rm_strobe_before", 8'(write_strobe), 8'd1);
        reset_n = 1'b0;
        model_reset();
        req[1] = 1'b1;
        #1;
        check("rm_strobe_async", 8'({write_strobe, read_strobe}), 8'h00);
        check("rm_grant_async", 8'(grant), 8'h00);
        check("rm_ack_async", 8'({m1_ack, m0_ack}), 8'h00);
        acks_in_rst = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (s_ack != 2'b00) acks_in_rst++;
        end
        check("rm_no_ack_in_reset", 8'(acks_in_rst), 8'd0);
        reset_n = 1'b1;
        first_own = -1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (s_ack != 2'b00 && first_own < 0) first_own = int'(s_ack[1]);
        end
        check("rm_first_owner", 8'(first_own), 8'd0);

        // Zero-setup instance: lone m0 writes held back-to-back
        z_req = 1'b1; z_we = 1'b1; z_addr = 8'h44; z_wdata = 8'h55;
        q_cyc.delete();
        first_s = -1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (zs_ws && first_s < 0) first_s = c;
            if (zs_ack) q_cyc.push_back(c);
            check("zs_grant", 8'(zs_grant), (c % 3 != 0) ? 8'h01 : 8'h00);
            if (c >= 1) check("zs_port_id", zs_id, 8'h44);
        end
        z_req = 1'b0;
        check("zs_first_strobe", 8'(first_s), 8'd1);
        check("zs_ack_count", 8'(q_cyc.size()), 8'd3);
        if (q_cyc.size() > 0) check("zs_first_ack", 8'(q_cyc[0]), 8'd2);
        for (int i = 0; i + 1 < q_cyc.size(); i++) begin
            check("zs_spacing", 8'(q_cyc[i + 1] - q_cyc[i]), 8'd3);
        end

        // Randomized traffic against the model
        do_reset();
        req = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            in_port = 8'($urandom);
            for (int m = 0; m < 2; m++) begin
                if (e_ack[m]) req[m] = ($urandom_range(3) != 0);
                else if (!req[m]) req[m] = ($urandom_range(2) == 0);
                we[m]    = 1'($urandom);
                addr[m]  = 8'($urandom);
                wdata[m] = 8'($urandom);
                lock[m]  = ($urandom_range(7) != 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/port_bus_arbiter.md
Name: port_bus_arbiter

Overview:
- Two-master arbiter sharing the 8-bit housekeeping port bus (port_id / out_port / write_strobe / read_strobe / in_port) that feeds the GPIO output registers and input-port mux.
- Lets the soft CPU (m0) and a second command source (m1, e.g. an Ethernet or UART command decoder) both issue port reads and writes.
- Scheduling is round-robin with bounded burst locking.
- Sits between the masters and the existing port decode logic; the port side is cycle-compatible with the current strobe protocol.

Parameters:
- SETUP_CYCLES, 1: cycles port_id/out_port are stable before the strobe; legal range 0..15.
- MAX_BURST, 16: maximum consecutive locked transactions per owner; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 transaction request
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  8  port number
- m0_wdata  in  8  write data
- m0_lock  in  1  request to keep bus for the next transaction
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  8  read data, valid when m0_ack = 1
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_ack, m1_rdata: as m0, for master 1
- port_id  out  8  port address to decode logic
- out_port  out  8  write data to decode logic
- write_strobe  out  1  one-cycle write strobe
- read_strobe  out  1  one-cycle read strobe
- in_port  in  8  combinational read data from port mux
- grant  out  2  one-hot current owner; 0 when idle

Behaviour:
- Reset:
  - Asynchronous on reset_n low: all outputs 0, state IDLE, rr_last = m1 (so m0 wins first), burst_cnt = 0.
  - Reset mid-transaction aborts it: strobes and ack drop immediately and are never issued for the aborted transaction.
  - Operation resumes from IDLE on the first clk edge after reset_n rises.
- States:
  - IDLE:
    - Samples m0_req/m1_req.
    - Lock rule: if the owner of the last completed transaction has req = 1, lock = 1 and burst_cnt < MAX_BURST, it wins.
    - Otherwise, one requester wins outright; if both request, the master other than rr_last wins.
    - On a win: latch the winner's we/addr/wdata into port_id/out_port, set grant, then go to SETUP (or straight to STROBE if SETUP_CYCLES = 0).
    - No request: stay in IDLE, grant = 0.
  - SETUP: counts SETUP_CYCLES cycles with strobes low, then goes to STROBE.
  - STROBE:
    - Exactly one cycle of write_strobe (we = 1) or read_strobe (we = 0).
    - On a read, in_port is registered at the end of this cycle into the owner's rdata.
  - ACK:
    - Owner's ack = 1 for one cycle, rdata valid.
    - Update rr_last = owner and burst_cnt, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 → strobe at cycle 1+SETUP_CYCLES → ack at cycle 2+SETUP_CYCLES.
- Back-to-back spacing: 3+SETUP_CYCLES cycles (4 at default).
- Master rules:
  - Hold req until ack; drop or re-present req in the cycle after ack.
  - we/addr/wdata are latched at grant, so changes after grant are ignored.
  - req is sampled only in IDLE; a req seen in IDLE in the cycle after ack starts a new transaction.
- Burst counting:
  - burst_cnt increments in ACK when the owner's lock = 1.
  - It clears when lock = 0 at ACK, when ownership changes, or when the count reaches MAX_BURST.
  - On reaching MAX_BURST, the other master has priority at the next IDLE if it is requesting.
  - A lone requester is always served regardless of burst_cnt.
- Output holding:
  - port_id/out_port hold their last values between transactions.
  - grant is valid from SETUP through ACK.
  - m*_rdata holds until that master's next read completes; writes leave it unchanged.
- Strobes are never asserted outside STROBE. Only one master is acked per transaction.

Test Plan:
- Lone write: m0 write addr 0x1F data 0x31 → port_id = 0x1F and out_port = 0x31 from cycle 1; write_strobe in cycle 2 only; m0_ack in cycle 3; grant = 01 in cycles 1–3.
- Lone read: m1 read addr 0x21 with in_port = 0xA5 → read_strobe once; m1_ack with m1_rdata = 0xA5; m0_rdata unchanged.
- Contention: both request continuously from reset, no lock → order m0, m1, m0, m1; ack spacing 4 cycles; never both acks in one cycle.
- Burst lock: m0 lock = 1 with continuous req, m1 req held → exactly 16 m0 transactions, then 1 m1, then m0 resumes; burst_cnt restarts at 0.
- Reset mid-transaction: reset_n low during STROBE → strobes, grant and ack go 0 without a clock edge; no ack for the aborted request; after release, m0 is served first.
- Zero setup: build with SETUP_CYCLES = 0, lone m0 write → strobe in cycle 1, ack in cycle 2, spacing 3 cycles.
